// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer (slave) and the fetch/adder side (master).
// Dbg_State_out mirrors the sequencer FSM state for checkers.
interface pc_sequencer_if;
  // Handshake: there is no valid/ready pair. Pc_Valid_out qualifies Pc_out in the
  // same cycle and is never back-pressured. Stall_in is a level hold request that
  // freezes the PC in the cycle it is sampled high.
  logic        Stall_in;
  logic        Jump_in;
  logic [31:0] Jump_Target_in;
  logic        Branch_in;
  logic [31:0] Branch_Target_in;
  logic [31:0] Adder_Res_in;
  logic        Adder_Carry_in;
  logic [31:0] Pc_out;
  logic [31:0] Inc_out;
  logic        Pc_Valid_out;
  logic        Redirect_Pend_out;
  logic        Fault_out;
  logic [1:0]  Dbg_State_out;

  modport master (
    output Stall_in, Jump_in, Jump_Target_in, Branch_in, Branch_Target_in,
           Adder_Res_in, Adder_Carry_in,
    input  Pc_out, Inc_out, Pc_Valid_out, Redirect_Pend_out, Fault_out, Dbg_State_out
  );

  modport slave (
    input  Stall_in, Jump_in, Jump_Target_in, Branch_in, Branch_Target_in,
           Adder_Res_in, Adder_Carry_in,
    output Pc_out, Inc_out, Pc_Valid_out, Redirect_Pend_out, Fault_out, Dbg_State_out
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage of the MIPS fetch path: PC register, stall-time redirect buffer, FSM.
// Optional macro WRAP_TRAP_EN: sequential wrap-around traps to EXC_VECTOR and sets a sticky fault.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] PC_INC     = 32'd4,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

`ifdef WRAP_TRAP_EN
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2, S_FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;
`endif

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic        pend_q;
  logic        valid_q;
  logic        fault_q;

  // A same-cycle jump always beats a branch.
  logic        req_d;
  logic [31:0] req_pc_d;

  always_comb begin
    req_d    = bus.Jump_in | bus.Branch_in;
    req_pc_d = bus.Jump_in ? bus.Jump_Target_in : bus.Branch_Target_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          valid_q <= 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (!bus.Stall_in) begin
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            if (req_d) begin
              pc_q <= req_pc_d;
            end else if (pend_q) begin
              pc_q <= pend_pc_q;
`ifdef WRAP_TRAP_EN
            end else if (bus.Adder_Carry_in) begin
              pc_q    <= EXC_VECTOR;
              fault_q <= 1'b1;
              state_q <= S_FAULT;
`endif
            end else begin
              pc_q <= bus.Adder_Res_in;
            end
          end else if (req_d) begin
            pend_pc_q <= req_pc_d;
            pend_q    <= 1'b1;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.Stall_in) begin
            if (req_d) pend_pc_q <= req_pc_d;
          end else begin
            pc_q      <= req_d ? req_pc_d : pend_pc_q;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            state_q   <= S_RUN;
          end
        end
`ifdef WRAP_TRAP_EN
        // Trapped: only sequential advance, redirects and carries ignored until reset.
        S_FAULT: begin
          if (!bus.Stall_in) pc_q <= bus.Adder_Res_in;
        end
`endif
        default: state_q <= S_BOOT;
      endcase
    end
  end

`ifndef WRAP_TRAP_EN
  logic unused_trap;
  assign unused_trap = bus.Adder_Carry_in ^ (^EXC_VECTOR);
`endif

  assign bus.Pc_out            = pc_q;
  assign bus.Inc_out           = PC_INC;
  assign bus.Pc_Valid_out      = valid_q;
  assign bus.Redirect_Pend_out = pend_q;
  assign bus.Fault_out         = fault_q;
  assign bus.Dbg_State_out     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver pushes the expected post-edge outputs,
// a monitor pops and compares after each rising edge.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef WRAP_TRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // external 32-bit adder: A = Pc_out, B = Inc_out (expected 4)
  logic [32:0] adder_sum;
  assign adder_sum          = {1'b0, bus.Pc_out} + 33'd4;
  assign bus.Adder_Res_in   = adder_sum[31:0];
  assign bus.Adder_Carry_in = adder_sum[32];

  // scoreboard: {pc, valid, pend, fault, inc}
  logic [66:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  // driver
  task automatic apply(input bit rst, input bit stall,
                       input bit jmp, input logic [31:0] jt,
                       input bit br, input logic [31:0] bt,
                       input logic [31:0] e_pc, input bit e_v, input bit e_p, input bit e_f);
    @(negedge clk);
    reset                = rst;
    bus.Stall_in         = stall;
    bus.Jump_in          = jmp;
    bus.Jump_Target_in   = jt;
    bus.Branch_in        = br;
    bus.Branch_Target_in = bt;
    exp_q.push_back({e_pc, e_v, e_p, e_f, 32'd4});
  endtask

  task automatic idle(input logic [31:0] e_pc, input bit e_v, input bit e_p, input bit e_f);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, e_pc, e_v, e_p, e_f);
  endtask

  // monitor
  initial begin
    logic [66:0] exp_v;
    logic [66:0] got_v;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {bus.Pc_out, bus.Pc_Valid_out, bus.Redirect_Pend_out, bus.Fault_out, bus.Inc_out};
        n_vec++;
        if (got_v !== exp_v) begin
          n_miss++;
          $display("FAIL vec%0d: got pc=%h valid=%b pend=%b fault=%b inc=%h, want pc=%h valid=%b pend=%b fault=%b inc=%h",
                   n_vec, got_v[66:35], got_v[34], got_v[33], got_v[32], got_v[31:0],
                   exp_v[66:35], exp_v[34], exp_v[33], exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    bus.Stall_in         = 1'b0;
    bus.Jump_in          = 1'b0;
    bus.Jump_Target_in   = 32'h0;
    bus.Branch_in        = 1'b0;
    bus.Branch_Target_in = 32'h0;

    // reset, BOOT ignores requests, free-run
    apply(1, 0, 0, 32'h0, 0, 32'h0, RST_PC, 0, 0, 0);
    apply(1, 0, 0, 32'h0, 0, 32'h0, RST_PC, 0, 0, 0);
    apply(0, 0, 1, 32'h0000_1234, 0, 32'h0, RST_PC, 1, 0, 0);
    idle(32'h0040_0004, 1, 0, 0);
    idle(32'h0040_0008, 1, 0, 0);
    idle(32'h0040_000C, 1, 0, 0);
    idle(32'h0040_0010, 1, 0, 0);
    // jump beats branch, then branch alone
    apply(0, 0, 1, 32'h0040_1000, 1, 32'h0040_0100, 32'h0040_1000, 1, 0, 0);
    apply(0, 0, 0, 32'h0, 1, 32'h0040_0040, 32'h0040_0040, 1, 0, 0);
    idle(32'h0040_0044, 1, 0, 0);
    // stall without request, then buffered redirects with overwrite
    apply(0, 1, 0, 32'h0, 0, 32'h0, 32'h0040_0044, 1, 0, 0);
    apply(0, 1, 0, 32'h0, 1, 32'h0040_0200, 32'h0040_0044, 1, 1, 0);
    apply(0, 1, 1, 32'h0040_2000, 0, 32'h0, 32'h0040_0044, 1, 1, 0);
    apply(0, 1, 0, 32'h0, 0, 32'h0, 32'h0040_0044, 1, 1, 0);
    idle(32'h0040_2000, 1, 0, 0);
    idle(32'h0040_2004, 1, 0, 0);
    // release with a new branch discards the buffer
    apply(0, 1, 1, 32'h0040_3000, 0, 32'h0, 32'h0040_2004, 1, 1, 0);
    apply(0, 1, 1, 32'h0040_2000, 1, 32'h0040_0500, 32'h0040_2004, 1, 1, 0);
    apply(0, 0, 0, 32'h0, 1, 32'h0040_0300, 32'h0040_0300, 1, 0, 0);
    idle(32'h0040_0304, 1, 0, 0);
    // reset while holding a pending redirect
    apply(0, 1, 0, 32'h0, 1, 32'h0040_5000, 32'h0040_0304, 1, 1, 0);
    apply(1, 1, 0, 32'h0, 0, 32'h0, RST_PC, 0, 0, 0);
    idle(RST_PC, 1, 0, 0);
    idle(32'h0040_0004, 1, 0, 0);
    // top of address space: redirect ignores carry, sequential wrap
    apply(0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'hFFFF_FFF8, 1, 0, 0);
    idle(32'hFFFF_FFFC, 1, 0, 0);
    apply(0, 0, 1, 32'h0040_0800, 0, 32'h0, 32'h0040_0800, 1, 0, 0);
    apply(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0);
    idle(WRAP ? 32'h8000_0180 : 32'h0000_0000, 1, 0, WRAP);
    idle(WRAP ? 32'h8000_0184 : 32'h0000_0004, 1, 0, WRAP);
    apply(0, 0, 1, 32'h0040_0000, 0, 32'h0, WRAP ? 32'h8000_0188 : 32'h0040_0000, 1, 0, WRAP);
    apply(0, 1, 0, 32'h0, 0, 32'h0, WRAP ? 32'h8000_0188 : 32'h0040_0000, 1, 0, WRAP);
    apply(1, 0, 0, 32'h0, 0, 32'h0, RST_PC, 0, 0, 0);
    idle(RST_PC, 1, 0, 0);

    // drain
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the MIPS fetch path.
- Holds the architectural PC and drives it into the 32-bit adder (A operand = PC, B operand = increment).
- Consumes the adder sum/carry as the sequential next PC, merges jump/branch redirects and fetch stalls, and flags sequential wrap-around.
- Sequential: PC register, pending-redirect buffer, 4-state FSM.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset (MIPS text base).
- PC_INC, 32'd4, constant driven on Inc_out (adder B operand).
- EXC_VECTOR, 32'h8000_0180, PC loaded on wrap fault (WRAP_TRAP_EN only).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- Stall_in  input  1  fetch stall; PC holds while high
- Jump_in  input  1  jump redirect request
- Jump_Target_in  input  32  jump target address
- Branch_in  input  1  taken-branch redirect request
- Branch_Target_in  input  32  branch target address
- Adder_Res_in  input  32  adder sum (PC + PC_INC)
- Adder_Carry_in  input  1  adder carry-out
- Pc_out  output  32  current PC; to fetch and adder A operand
- Inc_out  output  32  constant PC_INC; to adder B operand
- Pc_Valid_out  output  1  Pc_out is a fetchable address this cycle
- Redirect_Pend_out  output  1  a redirect is buffered during stall
- Fault_out  output  1  sequential wrap detected (sticky)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: Pc_out=RESET_PC, Pc_Valid_out=0, Redirect_Pend_out=0, Fault_out=0, pending buffer cleared, state=BOOT.
- Reset mid-operation overrides everything, including stall, pending redirect and FAULT.
- Inc_out is constant PC_INC at all times.
- Next-PC priority, evaluated in RUN with Stall_in=0: Jump_in > Branch_in > buffered pending redirect > Adder_Res_in.
- Latency: redirect or sequential target appears on Pc_out one cycle after the request cycle.
- States:
  - BOOT: one cycle after reset deassertion. Pc_out=RESET_PC, valid=0, all requests ignored. Next state RUN.
  - RUN: valid=1.
    - Stall_in=0: PC loads the next PC per priority; pending buffer cleared.
    - Stall_in=1 with no jump/branch: PC holds, stay RUN.
    - Stall_in=1 with jump/branch: PC holds; target captured into pending buffer (jump wins if both); Redirect_Pend_out=1 from next cycle; go HOLD.
  - HOLD: PC holds, valid=1.
    - New redirect while Stall_in=1: overwrites buffer (last writer wins; jump over branch in the same cycle).
    - Stall_in=0 with no new request: PC loads buffer, Redirect_Pend_out=0, go RUN.
    - Stall_in=0 with a new request: new request wins, buffer discarded, go RUN.
  - FAULT (WRAP_TRAP_EN only): entry defined under Optional Feature. Pc_out=EXC_VECTOR, valid=1, Fault_out=1 sticky. PC then advances sequentially through the adder; further carries are ignored. Exit only by reset.
- Carry is examined only when the sequential path is selected; redirects ignore Adder_Carry_in.
- Arithmetic: redirect targets are used as-is (no alignment check). All widths 32 bits; no internal add.

Optional Feature:
- Macro: WRAP_TRAP_EN.
- Defined: sequential advance with Adder_Carry_in=1 (e.g. PC=32'hFFFF_FFFC) enters FAULT and loads EXC_VECTOR instead of Adder_Res_in. Fault_out=1 from that edge.
- Undefined: no FAULT state. PC loads Adder_Res_in (wraps to 32'h0000_0000); Fault_out tied 0; EXC_VECTOR unused.

Test Plan:
- Reset, then free-run, adder modelled as PC+4 -> Pc_out 0x00400000 (valid=0 in BOOT), then 0x00400000, 0x00400004, 0x00400008 with valid=1.
- RUN at 0x00400010, Jump_in=1 to 0x00401000 and Branch_in=1 to 0x00400100 same cycle -> Pc_out=0x00401000 next cycle.
- Stall_in=1 three cycles; branch to 0x00400200 in cycle 1, jump to 0x00402000 in cycle 2 -> Pc_out held, Redirect_Pend_out=1. After release -> Pc_out=0x00402000, pend=0.
- PC=0xFFFFFFFC, adder returns 0x00000000 with carry=1 -> with WRAP_TRAP_EN: Pc_out=0x80000180, Fault_out=1 sticky. Without: Pc_out=0x00000000, Fault_out=0.
- reset asserted while in HOLD with pending redirect -> next cycle Pc_out=0x00400000, pend=0, valid=0; buffered target never applied.
- Stall released with a simultaneous branch to 0x00400300 while buffer holds 0x00402000 -> Pc_out=0x00400300.
